tmul_tile_sequencer: RTL and testbench

Sequential front/back end for the combinational TMUL_32_8mul8 tile multiplier. Accepts a serial 32-bit word stream and assembles the A vector (8 words) and B tile (8 rows × 8 words), holding them stable on the multiplier operand buses. After a fixed settle latency it captures the 8 × 64-bit results and streams them out with valid/ready backpressure. It is the producer and consumer of the multiplier's operand/result interface; the multiplier itself is instantiated outside this block.

---
 rtl/tmul_pkg.sv | 18 +
 rtl/tmul_result_drain.sv | 54 +++++
 rtl/tmul_tile_sequencer.sv | 118 +++++++++++
 tb/tb_tmul_tile_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmul_pkg.sv
// rtl/tmul_pkg.sv - shared defaults and FSM state type for the TMUL tile sequencer
package tmul_pkg;

    localparam int TMUL_N  = 8;
    localparam int TMUL_AW = 32;
    localparam int TMUL_CW = 64;

    localparam int A_WORDS = TMUL_N;
    localparam int B_WORDS = TMUL_N * TMUL_N;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

endpackage

// File: rtl/tmul_result_drain.sv
// rtl/tmul_result_drain.sv - result capture registers and valid/ready serializer
module tmul_result_drain #(
    parameter int N  = 8,
    parameter int CW = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [N*CW-1:0] mul_c,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [CW-1:0]   out_data,
    output logic            out_last,
    output logic            done
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] res [N];
    logic          armed;
    logic [IW-1:0] oidx;
    logic          xfer;
    logic          at_last;

    assign xfer     = out_valid & out_ready;
    assign at_last  = (oidx == IW'(N - 1));
    assign done     = xfer & at_last;
    assign out_data = res[oidx];
    assign out_last = out_valid & at_last;

    // valid rises one cycle after the capture edge, giving the settle latency its extra stage
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < N; j++) res[j] <= '0;
            armed     <= 1'b0;
            out_valid <= 1'b0;
            oidx      <= '0;
        end else begin
            armed <= load;
            if (load) begin
                for (int j = 0; j < N; j++) res[j] <= mul_c[j*CW +: CW];
            end
            if (armed) begin
                out_valid <= 1'b1;
            end else if (done) begin
                out_valid <= 1'b0;
                oidx      <= '0;
            end else if (xfer) begin
                oidx <= oidx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tmul_tile_sequencer.sv
// rtl/tmul_tile_sequencer.sv - operand loader, settle timer and result drain for the TMUL tile
module tmul_tile_sequencer
    import tmul_pkg::*;
#(
    parameter int N       = TMUL_N,
    parameter int AW      = TMUL_AW,
    parameter int CW      = TMUL_CW,
    parameter int MUL_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     in_data,
    output logic [N*AW-1:0]   mul_a,
    output logic [N*N*AW-1:0] mul_b,
    input  logic [N*CW-1:0]   mul_c,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW-1:0]     out_data,
    output logic              out_last,
    output logic              busy,
    output logic [15:0]       tile_count
);

    localparam int LW = $clog2(N * N);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int WW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    state_t        state;
    logic [LW-1:0] ld_cnt;
    logic [WW-1:0] wait_cnt;
    logic [AW-1:0] a_reg [N];
    logic [AW-1:0] b_reg [N*N];
    logic          accept;
    logic          capture;
    logic          drain_done;

    assign in_ready = (state == LOAD_A) || (state == LOAD_B);
    assign busy     = (state == COMPUTE) || (state == DRAIN);
    assign accept   = in_valid & in_ready;
    assign capture  = (state == COMPUTE) && (wait_cnt == WW'(MUL_LAT - 1));

    for (genvar j = 0; j < N; j++) begin : g_a
        assign mul_a[j*AW +: AW] = a_reg[j];
    end

    // B word index equals row*N+element, so the load counter addresses the tile directly
    for (genvar j = 0; j < N*N; j++) begin : g_b
        assign mul_b[j*AW +: AW] = b_reg[j];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD_A;
            ld_cnt     <= '0;
            wait_cnt   <= '0;
            tile_count <= 16'd0;
            for (int j = 0; j < N; j++)   a_reg[j] <= '0;
            for (int j = 0; j < N*N; j++) b_reg[j] <= '0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (accept) begin
                        a_reg[ld_cnt[IW-1:0]] <= in_data;
                        if (ld_cnt == LW'(N - 1)) begin
                            state  <= LOAD_B;
                            ld_cnt <= '0;
                        end else begin
                            ld_cnt <= ld_cnt + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        b_reg[ld_cnt] <= in_data;
                        if (ld_cnt == LW'(N * N - 1)) begin
                            state    <= COMPUTE;
                            ld_cnt   <= '0;
                            wait_cnt <= '0;
                        end else begin
                            ld_cnt <= ld_cnt + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (capture) state <= DRAIN;
                    else         wait_cnt <= wait_cnt + 1'b1;
                end
                DRAIN: begin
                    if (drain_done) begin
                        state      <= LOAD_A;
                        ld_cnt     <= '0;
                        wait_cnt   <= '0;
                        tile_count <= tile_count + 16'd1;
                    end
                end
                default: state <= LOAD_A;
            endcase
        end
    end

    tmul_result_drain #(
        .N  (N),
        .CW (CW)
    ) u_drain (
        .clk       (clk),
        .rst       (rst),
        .load      (capture),
        .mul_c     (mul_c),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (drain_done)
    );

endmodule

// File: tb/tb_tmul_tile_sequencer.sv
// tb/tb_tmul_tile_sequencer.sv - randomized self-checking bench with a behavioural tile model
module tb_tmul_tile_sequencer;

    localparam int N       = 8;
    localparam int AW      = 32;
    localparam int CW      = 64;
    localparam int MUL_LAT = 1;
    localparam int WORDS   = N + N * N;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [AW-1:0]     in_data = '0;
    logic [N*AW-1:0]   mul_a;
    logic [N*N*AW-1:0] mul_b;
    logic [N*CW-1:0]   mul_c;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [CW-1:0]     out_data;
    logic              out_last;
    logic              busy;
    logic [15:0]       tile_count;

    int total = 0;
    int bad   = 0;

    tmul_tile_sequencer #(.N(N), .AW(AW), .CW(CW), .MUL_LAT(MUL_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_c      (mul_c),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .tile_count (tile_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // multiplier stand-in: mode 0 is a fixed pattern, mode 1 a column dot product
    int stub_mode = 0;

    function automatic logic [CW-1:0] stub_elem(input int j, input logic [N*AW-1:0] a,
                                                input logic [N*N*AW-1:0] b, input int mode);
        logic [CW-1:0] acc;
        if (mode == 0) return 64'h100 + CW'(j);
        acc = CW'(j);
        for (int k = 0; k < N; k++) acc += CW'(a[k*AW +: AW]) * CW'(b[(k*N+j)*AW +: AW]);
        return acc;
    endfunction

    always_comb begin
        mul_c = '0;
        for (int j = 0; j < N; j++) mul_c[j*CW +: CW] = stub_elem(j, mul_a, mul_b, stub_mode);
    end

    // behavioural model: word counts and cycles since the tile completed loading
    logic [AW-1:0] ma [N];
    logic [AW-1:0] mb [N*N];
    int            m_words = 0;
    int            m_sent  = 0;
    int            m_since = 0;
    logic [15:0]   m_tiles = 16'd0;
    bit            m_live  = 1'b0;
    int            cyc     = 0;
    int            t_last  = 0;

    function automatic bit m_valid();
        return (m_words == WORDS) && (m_since >= MUL_LAT + 1);
    endfunction

    function automatic logic [CW-1:0] exp_c(input int i);
        logic [CW-1:0] acc;
        if (stub_mode == 0) return 64'h100 + CW'(i);
        acc = CW'(i);
        for (int k = 0; k < N; k++) acc += CW'(ma[k]) * CW'(mb[k*N+i]);
        return acc;
    endfunction

    always @(posedge clk) begin
        bit v;
        cyc++;
        v = m_valid();
        if (rst) begin
            m_words = 0; m_sent = 0; m_since = 0; m_tiles = 16'd0; m_live = 1'b1;
            for (int j = 0; j < N; j++)   ma[j] = '0;
            for (int j = 0; j < N*N; j++) mb[j] = '0;
        end else if (m_words < WORDS) begin
            if (in_valid) begin
                if (m_words < N) ma[m_words] = in_data;
                else             mb[m_words-N] = in_data;
                m_words++;
                if (m_words == WORDS) begin
                    m_since = 0;
                    t_last  = cyc;
                end
            end
        end else begin
            if (v && out_ready) begin
                m_sent++;
                if (m_sent == N) begin
                    m_sent = 0; m_words = 0; m_tiles++;
                end
            end
            if (m_since < 1000) m_since++;
        end
    end

    always @(negedge clk) begin
        bit v;
        int ai;
        int bi;
        if (m_live) begin
            v = m_valid();
            chk("in_ready", 64'(in_ready), 64'(m_words < WORDS));
            chk("busy", 64'(busy), 64'(m_words == WORDS));
            chk("out_valid", 64'(out_valid), 64'(v));
            chk("out_last", 64'(out_last), 64'(v && (m_sent == N-1)));
            if (v) chk($sformatf("out_data[%0d]", m_sent), out_data, exp_c(m_sent));
            chk("tile_count", 64'(tile_count), 64'(m_tiles));
            ai = 0;
            for (int j = 0; j < N; j++) if (mul_a[j*AW +: AW] !== ma[j]) begin ai = j; break; end
            chk($sformatf("mul_a[%0d]", ai), 64'(mul_a[ai*AW +: AW]), 64'(ma[ai]));
            bi = 0;
            for (int j = 0; j < N*N; j++) if (mul_b[j*AW +: AW] !== mb[j]) begin bi = j; break; end
            chk($sformatf("mul_b[%0d]", bi), 64'(mul_b[bi*AW +: AW]), 64'(mb[bi]));
        end
    end

    // downstream: ready pattern and a log of every result word it takes
    int            or_mode = 0;
    int            or_ph   = 0;
    int            first_v = -1;
    logic [CW-1:0] cap_data [$];
    bit            cap_last [$];

    always @(negedge clk) begin
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (or_ph % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        or_ph++;
        if (!rst && out_valid === 1'b1 && first_v < 0) first_v = cyc;
        if (!rst && out_valid === 1'b1 && out_ready) begin
            cap_data.push_back(out_data);
            cap_last.push_back(out_last);
        end
    end

    logic [AW-1:0] tile_w    [WORDS];
    bit            gap_after [WORDS];

    task automatic send_word(input logic [AW-1:0] w);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (in_ready !== 1'b1 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic send_tile();
        for (int i = 0; i < WORDS; i++) begin
            send_word(tile_w[i]);
            if (gap_after[i]) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_tiles(input logic [15:0] target);
        int guard;
        guard = 0;
        while (m_tiles != target && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) chk("tile_timeout", 64'(m_tiles), 64'(target));
    endtask

    task automatic fill_std();
        for (int i = 0; i < N; i++) tile_w[i] = AW'(i + 1);
        for (int j = 0; j < N; j++)
            for (int k = 0; k < N; k++) tile_w[N + j*N + k] = AW'(k + 1);
        for (int i = 0; i < WORDS; i++) gap_after[i] = 1'b0;
    endtask

    task automatic run_fixed(input string tag, input int exp_tiles, input bit lit_bus);
        int ai;
        int bi;
        stub_mode = 0;
        cap_data.delete();
        cap_last.delete();
        first_v = -1;
        send_tile();
        if (lit_bus) begin
            chk({tag, "_in_ready_after_last"}, 64'(in_ready), 64'd0);
            ai = 0;
            for (int j = 0; j < N; j++) if (mul_a[j*AW +: AW] !== AW'(j + 1)) begin ai = j; break; end
            chk({tag, "_lit_mul_a"}, 64'(mul_a[ai*AW +: AW]), 64'(ai + 1));
            bi = 0;
            for (int j = 0; j < N*N; j++) if (mul_b[j*AW +: AW] !== AW'(j % N + 1)) begin bi = j; break; end
            chk({tag, "_lit_mul_b"}, 64'(mul_b[bi*AW +: AW]), 64'(bi % N + 1));
        end
        wait_tiles(16'(exp_tiles));
        chk({tag, "_count"}, 64'(cap_data.size()), 64'd8);
        for (int i = 0; i < cap_data.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), cap_data[i], 64'h100 + 64'(i));
            chk($sformatf("%s_last%0d", tag, i), 64'(cap_last[i]), 64'(i == 7));
        end
        chk({tag, "_latency"}, 64'(first_v - t_last), 64'd2);
        chk({tag, "_tiles"}, 64'(tile_count), 64'(exp_tiles));
        chk({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid_low"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int tiles_done;
        int guard;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mul_a", 64'(|mul_a), 64'd0);
        chk("rst_mul_b", 64'(|mul_b), 64'd0);
        chk("rst_tile_count", 64'(tile_count), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_data", out_data, 64'd0);

        fill_std();
        or_mode = 0;
        run_fixed("basic", 1, 1'b1);

        fill_std();
        or_mode = 1;
        or_ph   = 0;
        run_fixed("bp", 2, 1'b1);

        fill_std();
        or_mode = 0;
        gap_after[2]  = 1'b1;
        gap_after[7]  = 1'b1;
        gap_after[39] = 1'b1;
        run_fixed("gaps", 3, 1'b1);

        fill_std();
        stub_mode = 0;
        send_tile();
        guard = 0;
        while (m_sent < 3 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) chk("drain_timeout", 64'(m_sent), 64'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_tile_count", 64'(tile_count), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);

        fill_std();
        run_fixed("post_rst", 1, 1'b1);

        tiles_done = 1;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < WORDS; i++) begin
                tile_w[i]    = $urandom;
                gap_after[i] = ($urandom_range(0, 3) == 0);
            end
            stub_mode = 1;
            or_mode   = int'($urandom_range(0, 2));
            or_ph     = 0;
            send_tile();
            repeat (3) begin
                in_valid = 1'b1;
                in_data  = $urandom;
                @(negedge clk);
            end
            in_valid = 1'b0;
            tiles_done++;
            wait_tiles(16'(tiles_done));
            chk($sformatf("rand%0d_tiles", r), 64'(tile_count), 64'(tiles_done));
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
